// File: rtl/rd_ht_budget_pkg.sv
// Shared types and width helpers for the read-guard head-tail table.
// An HT entry packs {id, head, tail, free}, with free as bit 0.
package rd_ht_budget_pkg;

  localparam int ID_W     = 4;
  localparam int LD_IDX_W = 2;

  function automatic int ht_entry_w(input int id_w, input int idx_w);
    return id_w + 2 * idx_w + 1;
  endfunction

  localparam int HT_ENTRY_W = ht_entry_w(ID_W, LD_IDX_W);

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [LD_IDX_W-1:0] head;
    logic [LD_IDX_W-1:0] tail;
    logic                free;
  } ht_entry_t;

  localparam ht_entry_t HT_ENTRY_RST = '{id: '0, head: '0, tail: '0, free: 1'b1};

endpackage

// File: rtl/ht_entry_reg.sv
// One HT entry register; takes d_i every cycle (one-cycle latency, no hold).
// Synchronous active-low reset loads the empty entry (free=1, all else 0).
module ht_entry_reg
  import rd_ht_budget_pkg::*;
#(
  parameter int EntryW = HT_ENTRY_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [EntryW-1:0] d_i,
  output logic [EntryW-1:0] q_o
);

  // Free sits in bit 0 for every entry width, so zero-extending it gives the reset entry.
  localparam logic [EntryW-1:0] RstVal = EntryW'(HT_ENTRY_RST.free);

  logic [EntryW-1:0] entry_d;
  logic [EntryW-1:0] entry_q;

  assign entry_d = d_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entry_q <= RstVal;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/rd_ht_budget.sv
// HT table registers with free/full flags, plus the combinational latency budget
// (beats of occupied LD slots, divided by the prescaler and saturated).
module rd_ht_budget
  import rd_ht_budget_pkg::*;
#(
  parameter int IdWidth      = 4,
  parameter int HtCapacity   = 4,
  parameter int MaxTxns      = 4,
  parameter int LdIdxWidth   = 2,
  parameter int LenWidth     = 8,
  parameter int AccuCntWidth = 10,
  parameter int PrescalerDiv = 1,
  localparam int HtEntryW    = IdWidth + 2 * LdIdxWidth + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [HtCapacity*HtEntryW-1:0] ht_d_i,
  output logic [HtCapacity*HtEntryW-1:0] ht_q_o,
  output logic [HtCapacity-1:0]          ht_free_o,
  output logic                           ht_full_o,
  input  logic [MaxTxns-1:0]             ld_free_i,
  input  logic [MaxTxns*LenWidth-1:0]    ld_len_i,
  output logic [AccuCntWidth-1:0]        accum_burst_len_o
);

  localparam int SumW = LenWidth + 1 + $clog2(MaxTxns + 1);
  localparam logic [SumW-1:0] DivV = SumW'(PrescalerDiv);

  if (PrescalerDiv < 1) begin : g_chk_div
    $error("PrescalerDiv must be at least 1");
  end
  if (HtCapacity < 1) begin : g_chk_ht
    $error("HtCapacity must be at least 1");
  end
  if (MaxTxns < 1) begin : g_chk_txn
    $error("MaxTxns must be at least 1");
  end
  if (LdIdxWidth < 1) begin : g_chk_idx
    $error("LdIdxWidth must be at least 1");
  end
  if (HtEntryW != ht_entry_w(IdWidth, LdIdxWidth)) begin : g_chk_w
    $error("HT entry width mismatch");
  end

  for (genvar i = 0; i < HtCapacity; i++) begin : g_ht
    ht_entry_reg #(
      .EntryW(HtEntryW)
    ) u_entry (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (ht_d_i[i*HtEntryW +: HtEntryW]),
      .q_o   (ht_q_o[i*HtEntryW +: HtEntryW])
    );
    assign ht_free_o[i] = ht_q_o[i*HtEntryW];
  end

  assign ht_full_o = ~|ht_free_o;

  // AND-gating keeps an X len on a free slot out of the sum.
  logic [SumW-1:0] beats [MaxTxns];
  for (genvar i = 0; i < MaxTxns; i++) begin : g_beats
    assign beats[i] = {SumW{~ld_free_i[i]}}
                    & (SumW'(ld_len_i[i*LenWidth +: LenWidth]) + SumW'(1));
  end

  logic [SumW-1:0] sum;
  logic [SumW-1:0] scaled;

  always_comb begin
    sum = '0;
    for (int i = 0; i < MaxTxns; i++) begin
      sum = sum + beats[i];
    end
  end

  assign scaled = sum / DivV;

  if (SumW > AccuCntWidth) begin : g_sat
    localparam logic [SumW-1:0] SatV = SumW'((1 << AccuCntWidth) - 1);
    assign accum_burst_len_o = (scaled > SatV) ? '1 : scaled[AccuCntWidth-1:0];
  end else begin : g_nosat
    assign accum_burst_len_o = AccuCntWidth'(scaled);
  end

endmodule

// File: tb/tb_rd_ht_budget.sv
// Bench for rd_ht_budget: directed HT/budget sequences, a budget vector table,
// and a randomized run against a spec-level model, with prescaler 1 and 4.
module tb_rd_ht_budget;

  localparam int EW = 9;
  localparam int HC = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [HC*EW-1:0] ht_d;
  logic [HC*EW-1:0] ht_q, ht_q4;
  logic [3:0]       ht_free, ht_free4;
  logic             full, full4;
  logic [3:0]       ld_free;
  logic [31:0]      ld_len;
  logic [9:0]       acc1, acc4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rd_ht_budget #(.PrescalerDiv(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .ht_d_i(ht_d), .ht_q_o(ht_q),
    .ht_free_o(ht_free), .ht_full_o(full), .ld_free_i(ld_free),
    .ld_len_i(ld_len), .accum_burst_len_o(acc1)
  );

  rd_ht_budget #(.PrescalerDiv(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .ht_d_i(ht_d), .ht_q_o(ht_q4),
    .ht_free_o(ht_free4), .ht_full_o(full4), .ld_free_i(ld_free),
    .ld_len_i(ld_len), .accum_burst_len_o(acc4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [3:0] id, input logic [1:0] h,
                                        input logic [1:0] t, input logic f);
    return {id, h, t, f};
  endfunction

  function automatic logic [HC*EW-1:0] rst_table();
    logic [HC*EW-1:0] r;
    for (int i = 0; i < HC; i++) r[i*EW +: EW] = ent(4'd0, 2'd0, 2'd0, 1'b1);
    return r;
  endfunction

  function automatic logic [3:0] free_of(input logic [HC*EW-1:0] t);
    logic [3:0] f;
    for (int i = 0; i < HC; i++) f[i] = t[i*EW];
    return f;
  endfunction

  function automatic int model_accum(input logic [3:0] fr, input logic [31:0] len, input int div);
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (!fr[i]) sum += int'(len[i*8 +: 8]) + 1;
    end
    sum = sum / div;
    if (sum > 1023) sum = 1023;
    return sum;
  endfunction

  typedef struct {
    logic [3:0]  fr;
    logic [31:0] len;
    logic [9:0]  e1;
    logic [9:0]  e4;
  } bvec_t;

  bvec_t tbl [6];

  initial begin
    logic [HC*EW-1:0] exp_ht;
    logic [3:0]       exp_free;

    tbl[0] = '{fr: 4'b0101, len: {8'd7, 8'bx, 8'd3, 8'bx},       e1: 10'd12,   e4: 10'd3};
    tbl[1] = '{fr: 4'b0000, len: 32'h0000_0000,                   e1: 10'd4,    e4: 10'd1};
    tbl[2] = '{fr: 4'b0000, len: 32'hffff_ffff,                   e1: 10'd1023, e4: 10'd256};
    tbl[3] = '{fr: 4'b1111, len: 32'hdead_beef,                   e1: 10'd0,    e4: 10'd0};
    tbl[4] = '{fr: 4'b1110, len: {8'bx, 8'bx, 8'bx, 8'd9},        e1: 10'd10,   e4: 10'd2};
    tbl[5] = '{fr: 4'b0011, len: {8'd255, 8'd254, 8'd0, 8'd0},    e1: 10'd511,  e4: 10'd127};

    rst_n   = 1'b0;
    ld_free = 4'hf;
    ld_len  = 32'h0;
    ht_d    = 36'({$urandom(), $urandom()});
    @(posedge clk);
    ht_d    = 36'({$urandom(), $urandom()});
    @(posedge clk);
    @(negedge clk);
    check("reset_ht_q", 64'(ht_q), 64'(rst_table()));
    check("reset_free", 64'(ht_free), 64'(4'b1111));
    check("reset_full", 64'(full), 64'(1'b0));
    check("reset_ht_q_div4", 64'(ht_q4), 64'(rst_table()));

    // Entry 2 loaded at the next edge, not before.
    rst_n = 1'b1;
    ht_d  = rst_table();
    ht_d[2*EW +: EW] = ent(4'hA, 2'd1, 2'd2, 1'b0);
    #1;
    check("latency_before_edge", 64'(ht_q[2*EW +: EW]), 64'(ent(4'd0, 2'd0, 2'd0, 1'b1)));
    @(posedge clk); #1;
    check("latency_entry2", 64'(ht_q[2*EW +: EW]), 64'(ent(4'hA, 2'd1, 2'd2, 1'b0)));
    check("latency_free", 64'(ht_free), 64'(4'b1011));
    check("latency_full", 64'(full), 64'(1'b0));

    // Fill every entry, then clear with a one-edge reset.
    @(negedge clk);
    for (int i = 0; i < HC; i++) ht_d[i*EW +: EW] = ent(4'(i + 3), 2'(i), 2'(3 - i), 1'b0);
    @(posedge clk); #1;
    check("full_free", 64'(ht_free), 64'(4'b0000));
    check("full_flag", 64'(full), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("clear_before_edge", 64'(ht_free), 64'(4'b0000));
    @(posedge clk); #1;
    check("clear_free", 64'(ht_free), 64'(4'b1111));
    check("clear_full", 64'(full), 64'(1'b0));
    check("clear_ht_q", 64'(ht_q), 64'(rst_table()));

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ld_free = tbl[k].fr;
      ld_len  = tbl[k].len;
      #1;
      check($sformatf("budget_div1_vec%0d", k), 64'(acc1), 64'(tbl[k].e1));
      check($sformatf("budget_div4_vec%0d", k), 64'(acc4), 64'(tbl[k].e4));
      #1;
    end

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 15) != 0);
      ht_d    = 36'({$urandom(), $urandom()});
      ld_free = 4'($urandom());
      ld_len  = (n % 3 == 0) ? (32'hf0f0_f0f0 | $urandom()) : $urandom();
      #1;
      check("rand_budget_div1", 64'(acc1), 64'(model_accum(ld_free, ld_len, 1)));
      check("rand_budget_div4", 64'(acc4), 64'(model_accum(ld_free, ld_len, 4)));
      exp_ht   = rst_n ? ht_d : rst_table();
      exp_free = free_of(exp_ht);
      @(posedge clk); #1;
      check("rand_ht_q", 64'(ht_q), 64'(exp_ht));
      check("rand_free", 64'(ht_free), 64'(exp_free));
      check("rand_full", 64'(full), 64'(exp_free == 4'b0000));
      check("rand_ht_q_div4", 64'(ht_q4), 64'(exp_ht));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_ht_budget.md
Name: rd_ht_budget

Overview:
- Bookkeeping slice of the read-guard transaction tracker.
- Holds the registered head-tail (HT) table, with one entry per live AXI read ID.
- Exposes each entry's free flag as a vector, plus an HT-full flag.
- Computes the dynamic latency budget: the accumulated burst beats of all occupied linked-data (LD) slots, scaled by the prescaler divisor.
- Sits between the read transaction manager (which drives next-state HT data) and the timeout counters (which consume the budget).

Parameters:
- IdWidth, 4, AXI ID width.
- HtCapacity, 4, number of HT entries; set to min(MaxUniqIds, MaxTxns) by the instantiator.
- MaxTxns, 4, number of LD slots.
- LdIdxWidth, 2, LD index width; equals max(1, clog2(MaxTxns)).
- LenWidth, 8, AXI burst length field width.
- AccuCntWidth, 10, width of the accumulated-budget output.
- PrescalerDiv, 1, prescaler division factor; must be at least 1.
- Derived localparam HtEntryW = IdWidth + 2*LdIdxWidth + 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- ht_d_i  in  HtCapacity*HtEntryW  next-state HT table; entry i occupies bits [i*HtEntryW +: HtEntryW].
- ht_q_o  out  HtCapacity*HtEntryW  registered HT table, same packing as ht_d_i.
- ht_free_o  out  HtCapacity  free flag of each registered entry.
- ht_full_o  out  1  no HT entry is free.
- ld_free_i  in  MaxTxns  LD slot free flags; 1 means the slot is empty.
- ld_len_i  in  MaxTxns*LenWidth  AXI len of each LD slot; slot i at bits [i*LenWidth +: LenWidth].
- accum_burst_len_o  out  AccuCntWidth  scaled total beats of all occupied slots.

Behaviour:
- Entry field order, MSB to LSB: id[IdWidth], head[LdIdxWidth], tail[LdIdxWidth], free[1]. The free flag is bit 0.
- HT registers:
  - On the rising edge of clk_i with rst_ni=0: every entry becomes id=0, head=0, tail=0, free=1.
  - Otherwise ht_q_o takes ht_d_i. Latency is one cycle, with no enable and no hold.
  - Reset has priority over any ht_d_i value.
  - Reset applied mid-operation clears all entries at that edge.
- Free vector:
  - ht_free_o[i] = ht_q_o entry i bit 0. Purely combinational from the registers.
  - Reset values: ht_free_o = all ones, ht_full_o = 0.
- Full flag: ht_full_o = ~|ht_free_o.
- Budget (combinational, no state):
  - sum = Σ over i with ld_free_i[i]=0 of (ld_len_i[i] + 1).
  - The sum is computed at width LenWidth+1+clog2(MaxTxns+1), so it never overflows.
  - scaled = floor(sum / PrescalerDiv).
  - accum_burst_len_o = scaled, saturated to 2^AccuCntWidth−1 if it exceeds that value.
  - All slots free gives 0.
  - A free slot contributes nothing, regardless of its len value.
  - The output does not depend on rst_ni.
- X-safety: a free LD slot's len may be X without corrupting the sum. Masking uses AND or mux gating, not multiplication.
- Elaboration checks: PrescalerDiv>=1; HtCapacity>=1; MaxTxns>=1; LdIdxWidth>=1.

Decomposition:
- Package rd_ht_budget_pkg holds:
  - HtEntryW function/localparam helpers;
  - typedef ht_entry_t, packed {id, head, tail, free}, parameterised through the package width defaults;
  - the reset-entry constant HT_ENTRY_RST (all zero except free=1).
- One sub-module, ht_entry_reg: a single HT entry register with synchronous active-low reset to HT_ENTRY_RST. It is generated HtCapacity times.
- The budget adder is a generate/for loop inside the top module.

Test Plan:
- Reset: hold rst_ni=0 for 2 edges with ht_d_i random. Required: ht_q_o entries = {0,0,0,1}, ht_free_o=4'b1111, ht_full_o=0.
- Register latency, using id=4'hA, head=1, tail=2, free=0:
  - Release reset and drive entry 2 with these values at edge N.
  - Required: ht_q_o entry 2 shows exactly these values after edge N, not before; ht_free_o=4'b1011.
- Full, then synchronous clear:
  - Drive all entries with free=0. Required: ht_free_o=0, ht_full_o=1.
  - Then assert rst_ni=0 for one edge. Required: ht_free_o=4'b1111 only after that edge.
- Budget masking: ld_free_i=4'b0101, len={slot3=7, slot2=X, slot1=3, slot0=X}, PrescalerDiv=1. Required: accum_burst_len_o=12 (8+4).
- Budget scaling and saturation:
  - PrescalerDiv=4, all slots occupied, len=0 each: required accum=1.
  - PrescalerDiv=1, all slots occupied, len=255 each: sum 1024, required accum=1023 (saturated).
- Empty: ld_free_i=4'b1111 with any len values. Required: accum_burst_len_o=0.
